// File: rtl/game_sequencer.sv
// game_sequencer
//   Game-state controller for the Flappy VGA design. It turns the centre
//   button into start / acknowledge events, tracks lives and score, and
//   sequences the movement datapaths through Start/Ack/Run/Freeze.
//
//   state | meaning
//   IDLE  | waiting for a button press to start a game
//   RUN   | game in progress, movement enabled
//   HIT   | non-fatal hit, frozen for GRACE_TICKS ticks
//   OVER  | no lives left, Flash blinking, waiting for acknowledge
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Tick                  game-pace enable (grace and flash counters only)
//   BtnC                  raw centre button (asynchronous)
//   Collide, Coin_Hit     synchronous levels from obstacle / coin logic
//   Start_Pulse/Ack_Pulse one-cycle strobes to RAM and flight control
//   Run, Freeze           movement enable / movement hold
//   Score, Lives, Flash   game status for the renderer
//   Hi_Score              best score, present only with GAME_HISCORE_EN
//   Q_Idle..Q_Over        one-hot state
//
// Build option: define GAME_HISCORE_EN to add the Hi_Score register/port.
module game_sequencer #(
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 64,
  parameter int FLASH_TICKS = 8,
  parameter int SCORE_MAX   = 999
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Tick,
  input  logic       BtnC,
  input  logic       Collide,
  input  logic       Coin_Hit,
  output logic       Start_Pulse,
  output logic       Ack_Pulse,
  output logic       Run,
  output logic       Freeze,
  output logic [9:0] Score,
`ifdef GAME_HISCORE_EN
  output logic [9:0] Hi_Score,
`endif
  output logic [1:0] Lives,
  output logic       Flash,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Hit,
  output logic       Q_Over
);

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_RUN  = 4'b0010;
  localparam logic [3:0] ST_HIT  = 4'b0100;
  localparam logic [3:0] ST_OVER = 4'b1000;

  localparam logic [9:0] SCORE_CAP  = 10'(SCORE_MAX);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  // Counters run 0..N-1; the tick seen at N-1 is the N-th tick.
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_TICKS - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_TICKS - 1);

  logic       btn_s1, btn_s2, btn_dly;
  logic       coll_dly, coin_dly;
  logic       btn_edge, coll_edge, coin_edge;
  logic [3:0] state, state_nxt;
  logic [9:0] score_nxt, coin_score;
  logic [1:0] lives_nxt;
  logic       flash_nxt, start_nxt, ack_nxt;
  logic [7:0] grace_cnt, grace_nxt;
  logic [7:0] flash_cnt, fcnt_nxt;

  assign btn_edge  = btn_s2 & ~btn_dly;
  // Collide/Coin_Hit are already synchronous, so the raw level is used to
  // react on the first high sample.
  assign coll_edge = Collide & ~coll_dly;
  assign coin_edge = Coin_Hit & ~coin_dly;

  assign coin_score = (Score >= SCORE_CAP) ? SCORE_CAP : Score + 10'd1;

  always_comb begin
    state_nxt = state;
    score_nxt = Score;
    lives_nxt = Lives;
    flash_nxt = Flash;
    grace_nxt = grace_cnt;
    fcnt_nxt  = flash_cnt;
    start_nxt = 1'b0;
    ack_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_edge) begin
          state_nxt = ST_RUN;
          start_nxt = 1'b1;
          score_nxt = 10'd0;
          lives_nxt = LIVES_INIT;
        end
      end
      ST_RUN: begin
        if (coin_edge) score_nxt = coin_score;
        if (coll_edge) begin
          if (Lives > 2'd1) begin
            lives_nxt = Lives - 2'd1;
            grace_nxt = 8'd0;
            state_nxt = ST_HIT;
          end else begin
            lives_nxt = 2'd0;
            fcnt_nxt  = 8'd0;
            flash_nxt = 1'b0;
            state_nxt = ST_OVER;
          end
        end
      end
      ST_HIT: begin
        if (Tick) begin
          if (grace_cnt == GRACE_LAST) state_nxt = ST_RUN;
          else                         grace_nxt = grace_cnt + 8'd1;
        end
      end
      ST_OVER: begin
        if (Tick) begin
          if (flash_cnt == FLASH_LAST) begin
            flash_nxt = ~Flash;
            fcnt_nxt  = 8'd0;
          end else begin
            fcnt_nxt  = flash_cnt + 8'd1;
          end
        end
        // Acknowledge wins over a coincident flash toggle.
        if (btn_edge) begin
          ack_nxt   = 1'b1;
          flash_nxt = 1'b0;
          fcnt_nxt  = 8'd0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_dly     <= 1'b0;
      coll_dly    <= 1'b0;
      coin_dly    <= 1'b0;
      state       <= ST_IDLE;
      Score       <= 10'd0;
      Lives       <= 2'd0;
      Flash       <= 1'b0;
      grace_cnt   <= 8'd0;
      flash_cnt   <= 8'd0;
      Start_Pulse <= 1'b0;
      Ack_Pulse   <= 1'b0;
      Run         <= 1'b0;
      Freeze      <= 1'b0;
    end else begin
      btn_s1      <= BtnC;
      btn_s2      <= btn_s1;
      btn_dly     <= btn_s2;
      coll_dly    <= Collide;
      coin_dly    <= Coin_Hit;
      state       <= state_nxt;
      Score       <= score_nxt;
      Lives       <= lives_nxt;
      Flash       <= flash_nxt;
      grace_cnt   <= grace_nxt;
      flash_cnt   <= fcnt_nxt;
      Start_Pulse <= start_nxt;
      Ack_Pulse   <= ack_nxt;
      Run         <= (state_nxt == ST_RUN);
      Freeze      <= (state_nxt == ST_HIT) || (state_nxt == ST_OVER);
    end
  end

`ifdef GAME_HISCORE_EN
  // Compared against the score being written on the losing edge, so a coin
  // captured on that same edge still counts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Hi_Score <= 10'd0;
    end else if ((state == ST_RUN) && (state_nxt == ST_OVER) && (score_nxt > Hi_Score)) begin
      Hi_Score <= score_nxt;
    end
  end
`endif

  assign Q_Idle = state[0];
  assign Q_Run  = state[1];
  assign Q_Hit  = state[2];
  assign Q_Over = state[3];

endmodule
